// File: rtl/aibcr3_merge_align_if.sv
// aibcr3_merge_align_if
// Bundles the complementary receive pair, the error-clear control and the
// recombined data/status outputs of aibcr3_merge_align.
// master: the side driving the pair (bench / upstream pad logic).
// slave : the merge/align block itself.
interface aibcr3_merge_align_if #(
   parameter int ERR_CNT_W = 8
);
   logic                 din_p;
   logic                 din_n;
   logic                 clr_err;
   logic                 dout;
   logic                 dout_vld;
   logic                 pair_err;
   logic [ERR_CNT_W-1:0] err_cnt;
   logic                 locked;

   modport master (
      output din_p, din_n, clr_err,
      input  dout, dout_vld, pair_err, err_cnt, locked
   );

   modport slave (
      input  din_p, din_n, clr_err,
      output dout, dout_vld, pair_err, err_cnt, locked
   );
endinterface

// File: rtl/aibcr3_merge_align.sv
// aibcr3_merge_align
// Receive-side merge of an AIB complementary pair: two-flop synchroniser per
// leg, complementarity check, run-length glitch filter, lock/hold FSM and an
// optional saturating error counter.
// Build option AIBCR3_MERGE_ERRCNT_EN: when defined, err_cnt counts
// non-complementary samples and clr_err clears it; when undefined err_cnt is
// tied to zero, clr_err is ignored and no counter flops exist.
module aibcr3_merge_align #(
   parameter int FILT_DEPTH = 2,
   parameter int LOCK_CNT   = 4,
   parameter int ERR_CNT_W  = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   aibcr3_merge_align_if.slave       bus
);

   localparam int FCW = $clog2(FILT_DEPTH + 1);
   localparam int LCW = $clog2(LOCK_CNT + 1);
   localparam logic [FCW-1:0] FILT_MAX = FCW'(FILT_DEPTH);
   localparam logic [LCW-1:0] LOCK_MAX = LCW'(LOCK_CNT);

   typedef struct packed {
      logic p;
      logic n;
   } pair_t;

   // The N leg resets high so the pair looks like a valid (0,1) out of reset.
   localparam pair_t PAIR_RST = '{p: 1'b0, n: 1'b1};

   typedef enum logic [1:0] {
      ST_UNLOCK = 2'd0,
      ST_ACQ    = 2'd1,
      ST_LOCK   = 2'd2,
      ST_HOLD   = 2'd3
   } state_t;

   // ------------------------------------------------------------------
   // Synchroniser
   // ------------------------------------------------------------------
   pair_t sync1_q, sync2_q;
   logic  sp, sn, valid;

   // Two flops per leg bring the asynchronous pair into clk.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= PAIR_RST;
         sync2_q <= PAIR_RST;
      end else begin
         sync1_q <= '{p: bus.din_p, n: bus.din_n};
         sync2_q <= sync1_q;
      end
   end

   assign sp    = sync2_q.p;
   assign sn    = sync2_q.n;
   assign valid = sp ^ sn;

   // ------------------------------------------------------------------
   // Glitch filter
   // ------------------------------------------------------------------
   logic           cand_q, cand_d;
   logic [FCW-1:0] fcnt_q, fcnt_d;
   logic           dout_q, dout_d;

   // Track the current run of identical valid samples; an invalid sample
   // breaks the run but keeps the candidate value, and dout only moves once
   // the run is FILT_DEPTH long.
   always_comb begin
      cand_d = cand_q;
      fcnt_d = fcnt_q;
      dout_d = dout_q;
      if (!valid) begin
         fcnt_d = '0;
      end else if (sp == cand_q) begin
         if (fcnt_q != FILT_MAX)
            fcnt_d = fcnt_q + 1'b1;
      end else begin
         cand_d = sp;
         fcnt_d = FCW'(1);
      end
      if (valid && (fcnt_d == FILT_MAX))
         dout_d = cand_d;
   end

   // Filter state and recombined output.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cand_q <= 1'b0;
         fcnt_q <= '0;
         dout_q <= 1'b0;
      end else begin
         cand_q <= cand_d;
         fcnt_q <= fcnt_d;
         dout_q <= dout_d;
      end
   end

   // ------------------------------------------------------------------
   // Lock FSM
   // ------------------------------------------------------------------
   state_t         state_q, state_d;
   logic [LCW-1:0] lcnt_q, lcnt_d;
   logic           locked_q, locked_d;
   logic           perr_q, perr_d;

   // Next state: LOCK_CNT consecutive valid samples to lock, one bad sample
   // is ridden out in HOLD, a second consecutive one drops lock.
   always_comb begin
      state_d = state_q;
      lcnt_d  = lcnt_q;
      case (state_q)
         ST_UNLOCK: begin
            if (valid) begin
               lcnt_d  = LCW'(1);
               state_d = (LOCK_CNT == 1) ? ST_LOCK : ST_ACQ;
            end
         end
         ST_ACQ: begin
            if (valid) begin
               lcnt_d = lcnt_q + 1'b1;
               if (lcnt_d == LOCK_MAX)
                  state_d = ST_LOCK;
            end else begin
               lcnt_d  = '0;
               state_d = ST_UNLOCK;
            end
         end
         ST_LOCK: begin
            if (!valid)
               state_d = ST_HOLD;
         end
         ST_HOLD: begin
            if (valid) begin
               state_d = ST_LOCK;
            end else begin
               lcnt_d  = '0;
               state_d = ST_UNLOCK;
            end
         end
         default: begin
            lcnt_d  = '0;
            state_d = ST_UNLOCK;
         end
      endcase
      locked_d = (state_d == ST_LOCK) || (state_d == ST_HOLD);
      perr_d   = ~valid;
   end

   // FSM state, registered lock status and the per-sample error flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_UNLOCK;
         lcnt_q   <= '0;
         locked_q <= 1'b0;
         perr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         lcnt_q   <= lcnt_d;
         locked_q <= locked_d;
         perr_q   <= perr_d;
      end
   end

   // ------------------------------------------------------------------
   // Error counter
   // ------------------------------------------------------------------
`ifdef AIBCR3_MERGE_ERRCNT_EN
   logic [ERR_CNT_W-1:0] err_q, err_d;

   // Saturating count of bad samples; clear wins over a same-cycle error.
   always_comb begin
      err_d = err_q;
      if (bus.clr_err)
         err_d = '0;
      else if (!valid && (err_q != {ERR_CNT_W{1'b1}}))
         err_d = err_q + 1'b1;
   end

   // Error counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         err_q <= '0;
      else
         err_q <= err_d;
   end

   assign bus.err_cnt = err_q;
`else
   // Counter not built: clr_err has nothing to act on.
   logic unused_clr_err;
   assign unused_clr_err = bus.clr_err;
   assign bus.err_cnt    = '0;
`endif

   assign bus.dout     = dout_q;
   assign bus.dout_vld = locked_q;
   assign bus.locked   = locked_q;
   assign bus.pair_err = perr_q;

endmodule

// File: tb/tb_aibcr3_merge_align.sv
// tb_aibcr3_merge_align
// Directed table for the documented scenarios, hand sequences for error
// saturation / clear and mid-cycle reset, then randomized pairs checked
// against a history-based reference model.
module tb_aibcr3_merge_align;

   localparam int FD  = 2;
   localparam int LC  = 4;
   localparam int EW  = 4;
   localparam int EMAX = (1 << EW) - 1;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   aibcr3_merge_align_if #(.ERR_CNT_W(EW)) bus ();

   aibcr3_merge_align #(
      .FILT_DEPTH (FD),
      .LOCK_CNT   (LC),
      .ERR_CNT_W  (EW)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   // Expected err_cnt for the current build.
   function automatic int eexp(input int v);
`ifdef AIBCR3_MERGE_ERRCNT_EN
      return v;
`else
      return 0 * v;
`endif
   endfunction

   task automatic chk_all(input string tag, input int d, input int lk, input int pe, input int ec);
      chk({tag, ".dout"},     int'(bus.dout),     d);
      chk({tag, ".locked"},   int'(bus.locked),   lk);
      chk({tag, ".dout_vld"}, int'(bus.dout_vld), lk);
      chk({tag, ".pair_err"}, int'(bus.pair_err), pe);
      chk({tag, ".err_cnt"},  int'(bus.err_cnt),  eexp(ec));
   endtask

   // Drive at the falling edge, sample 1 time unit after the rising edge.
   task automatic step(input logic p, input logic n, input logic c);
      @(negedge clk);
      bus.din_p   = p;
      bus.din_n   = n;
      bus.clr_err = c;
      @(posedge clk);
      #1;
   endtask

   // Assert reset mid high phase, check outputs clear, release one cycle later.
   task automatic apply_reset(input logic p, input logic n, input string tag);
      #2;
      rst_n       = 1'b0;
      bus.din_p   = p;
      bus.din_n   = n;
      bus.clr_err = 1'b0;
      #1;
      chk_all(tag, 0, 0, 0, 0);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
   endtask

   typedef struct {
      logic p;
      logic n;
      logic clr;
      int   dout;
      int   lk;
      int   perr;
      int   err;
   } vec_t;

   vec_t tbl[18];

   // Reference model state
   logic [1:0] pinq[$];
   logic [1:0] hist[$];
   int dout_m, lk_m, perr_m, err_m;

   task automatic model_edge(input logic [1:0] pins, input logic clr);
      logic [1:0] s;
      int run, vrun;
      pinq.push_back(pins);
      s = pinq.pop_front();
      hist.push_back(s);
      run = 0;
      for (int i = hist.size() - 1; i >= 0 && run < FD; i--) begin
         if ((^hist[i]) && hist[i] == s) run++;
         else break;
      end
      if ((^s) && run >= FD) dout_m = int'(s[1]);
      vrun = 0;
      for (int i = hist.size() - 1; i >= 0 && vrun < LC; i--) begin
         if (^hist[i]) vrun++;
         else break;
      end
      if (lk_m == 0) begin
         if (vrun >= LC) lk_m = 1;
      end else if (hist.size() >= 2) begin
         if (!(^hist[hist.size()-1]) && !(^hist[hist.size()-2])) lk_m = 0;
      end
      perr_m = (^s) ? 0 : 1;
      if (clr) err_m = 0;
      else if (!(^s) && err_m < EMAX) err_m++;
   endtask

   initial begin
      logic [1:0] cur;
      int hold;
      logic c;

      bus.din_p = 1'b0; bus.din_n = 1'b1; bus.clr_err = 1'b0;

      // p,n,clr | dout,locked,pair_err,err_cnt (counter-enabled values)
      tbl[0]  = '{1,0,0, 0,0,0,0};
      tbl[1]  = '{1,0,0, 0,0,0,0};
      tbl[2]  = '{1,0,0, 0,0,0,0};
      tbl[3]  = '{1,0,0, 1,1,0,0};
      tbl[4]  = '{0,1,0, 1,1,0,0};
      tbl[5]  = '{1,0,0, 1,1,0,0};
      tbl[6]  = '{1,0,0, 1,1,0,0};
      tbl[7]  = '{1,1,0, 1,1,0,0};
      tbl[8]  = '{1,0,0, 1,1,0,0};
      tbl[9]  = '{1,0,0, 1,1,1,1};
      tbl[10] = '{1,1,0, 1,1,0,1};
      tbl[11] = '{1,1,0, 1,1,0,1};
      tbl[12] = '{1,0,0, 1,1,1,2};
      tbl[13] = '{1,0,0, 1,0,1,3};
      tbl[14] = '{1,0,0, 1,0,0,3};
      tbl[15] = '{1,0,0, 1,0,0,3};
      tbl[16] = '{1,0,0, 1,0,0,3};
      tbl[17] = '{1,0,0, 1,1,0,3};

      // Lock-up, single-cycle polarity glitch, single and double bad samples
      apply_reset(1'b1, 1'b0, "rst0");
      for (int i = 0; i < 18; i++) begin
         step(tbl[i].p, tbl[i].n, tbl[i].clr);
         chk_all($sformatf("tbl[%0d]", i), tbl[i].dout, tbl[i].lk, tbl[i].perr, tbl[i].err);
      end

      // Long run of (0,0): counter saturates, lock drops
      for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0);
      chk_all("sat", 1, 0, 1, EMAX);
      // Clear together with an invalid sample
      step(1'b0, 1'b0, 1'b1);
      chk_all("clr", 1, 0, 1, 0);
      step(1'b0, 1'b0, 1'b0);
      chk_all("post_clr", 1, 0, 1, 1);

      // Relock at dout=1, then asynchronous reset mid-cycle
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0);
      chk_all("relock", 1, 1, 0, 3);
      apply_reset(1'b0, 1'b1, "midrst");
      for (int i = 1; i <= 4; i++) begin
         step(1'b0, 1'b1, 1'b0);
         if (i == 3) chk_all("rel_e3", 0, 0, 0, 0);
         if (i == 4) chk_all("rel_e4", 0, 1, 0, 0);
      end

      // Randomized pairs against the reference model
      apply_reset(1'b0, 1'b1, "rst_rand");
      pinq.delete(); hist.delete();
      pinq.push_back(2'b01); pinq.push_back(2'b01);
      dout_m = 0; lk_m = 0; perr_m = 0; err_m = 0;
      hold = 0; cur = 2'b01;
      for (int cyc = 0; cyc < 1500; cyc++) begin
         if (hold == 0) begin
            if ($urandom_range(0, 9) < 7) begin
               cur[1] = 1'($urandom_range(0, 1));
               cur[0] = ~cur[1];
               hold   = $urandom_range(1, 6);
            end else begin
               cur  = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00;
               hold = $urandom_range(1, 3);
            end
         end
         hold--;
         c = ($urandom_range(0, 19) == 0);
         step(cur[1], cur[0], c);
         model_edge(cur, c);
         chk_all($sformatf("rand[%0d]", cyc), dout_m, lk_m, perr_m, err_m);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
